ps2_kbd_tx: RTL

Device-side PS/2 transmitter: the keyboard end of the PS/2 link that `ps2_keyboard` receives from. It accepts scan-code bytes over a valid/ready handshake and drives `ps2_clk`/`ps2_data` open-collector-style as 11-bit frames (start, 8 data LSB-first, odd parity, stop). It is used as a synthesizable keyboard emulator for board loopback and self-test, replacing the behavioural keyboard model.

---
 rtl/ps2_kbd_tx.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_tx
// Purpose  : Device-side (keyboard end) PS/2 transmitter. Accepts scan-code
//            bytes over valid/ready and sends each one as an 11-bit frame:
//            start 0, 8 data bits LSB first, odd parity, stop 1. Each frame
//            is followed by an idle gap with both lines high.
// Ports    : clk          - system clock, the only clock
//            clrn         - asynchronous active-low reset
//            din          - scan-code byte
//            din_valid    - din is valid
//            din_ready    - a byte can be accepted (not full)
//            host_inhibit - host holds the clock low; stops or aborts a frame
//            ps2_clk      - PS/2 clock, idle high
//            ps2_data     - PS/2 data, idle high
//            busy         - a frame or inter-frame gap is in progress
// Config   : `PS2_TX_FIFO_EN defined   -> FIFO_DEPTH-entry FIFO
//            `PS2_TX_FIFO_EN undefined -> single-byte holding register
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_tx #(
    parameter int HALF_PERIOD = 4000,  // clk cycles per ps2_clk half period, >= 2
    parameter int GAP_CYCLES  = 8000,  // idle cycles after every stop bit, >= 1
    parameter int FIFO_DEPTH  = 8      // power of two, >= 2; FIFO build only
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       host_inhibit,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    localparam int c_MAXCNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int c_CW     = $clog2(c_MAXCNT + 1);
    localparam logic [c_CW-1:0] c_HP_LAST  = c_CW'(HALF_PERIOD - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST = c_CW'(GAP_CYCLES - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BIT_HI = 2'd1;
    localparam logic [1:0] c_BIT_LO = 2'd2;
    localparam logic [1:0] c_GAP    = 2'd3;

    localparam logic [3:0] c_STOP_IDX = 4'd10;

    // ------------------------------------------------------------------------
    // Byte storage
    // ------------------------------------------------------------------------
    logic       w_full;
    logic       w_not_empty;
    logic [7:0] w_head;
    logic       w_push;
    logic       w_pop;

    assign din_ready = ~w_full;
    assign w_push    = din_valid & ~w_full;

`ifdef PS2_TX_FIFO_EN
    localparam int c_AW = $clog2(FIFO_DEPTH);

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_full      = (r_count == (c_AW + 1)'(FIFO_DEPTH));
    assign w_not_empty = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
`else
    logic [7:0] r_hold;
    logic       r_held;

    // Push is only possible while empty, so push and pop never coincide.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_hold <= 8'h00;
            r_held <= 1'b0;
        end else begin
            if (w_push) begin
                r_hold <= din;
            end
            if (w_pop) begin
                r_held <= 1'b0;
            end else if (w_push) begin
                r_held <= 1'b1;
            end
        end
    end

    assign w_full      = r_held;
    assign w_not_empty = r_held;
    assign w_head      = r_hold;
`endif

    // ------------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [3:0]      r_bit_idx;
    logic [8:0]      r_shift;     // {odd parity, data}
    logic            r_clk;
    logic            r_data;

    logic [1:0]      w_state_nx;
    logic [c_CW-1:0] w_cnt_nx;
    logic [3:0]      w_idx_nx;
    logic            w_clk_nx;
    logic            w_data_nx;
    logic            w_latch;
    logic            w_abort;
    logic [3:0]      w_idx_inc;
    logic [10:0]     w_frame;

    // Whole frame indexed by bit_idx: start, data LSB first, parity, stop.
    assign w_frame   = {1'b1, r_shift, 1'b0};
    assign w_idx_inc = r_bit_idx + 4'd1;
    // The stop bit is never aborted; inhibit then only blocks the next start.
    assign w_abort   = host_inhibit && (r_bit_idx < c_STOP_IDX);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_idx_nx   = r_bit_idx;
        w_clk_nx   = r_clk;
        w_data_nx  = r_data;
        w_latch    = 1'b0;
        w_pop      = 1'b0;

        case (r_state)
            c_IDLE: begin
                w_cnt_nx  = '0;
                w_clk_nx  = 1'b1;
                w_data_nx = 1'b1;
                if (w_not_empty && !host_inhibit) begin
                    w_state_nx = c_BIT_HI;
                    w_idx_nx   = 4'd0;
                    w_latch    = 1'b1;
                    w_data_nx  = 1'b0;     // start bit
                end
            end

            c_BIT_HI: begin
                if (w_abort) begin
                    w_state_nx = c_GAP;
                    w_cnt_nx   = '0;
                    w_clk_nx   = 1'b1;
                    w_data_nx  = 1'b1;
                end else if (r_cnt == c_HP_LAST) begin
                    w_state_nx = c_BIT_LO;
                    w_cnt_nx   = '0;
                    w_clk_nx   = 1'b0;
                end
            end

            c_BIT_LO: begin
                if (w_abort) begin
                    w_state_nx = c_GAP;
                    w_cnt_nx   = '0;
                    w_clk_nx   = 1'b1;
                    w_data_nx  = 1'b1;
                end else if (r_cnt == c_HP_LAST) begin
                    w_cnt_nx = '0;
                    w_clk_nx = 1'b1;
                    if (r_bit_idx == c_STOP_IDX) begin
                        w_state_nx = c_GAP;
                        w_pop      = 1'b1;
                        w_data_nx  = 1'b1;
                    end else begin
                        // Data moves only on entry to BIT_HI, a full half
                        // period away from either falling edge.
                        w_state_nx = c_BIT_HI;
                        w_idx_nx   = w_idx_inc;
                        w_data_nx  = w_frame[w_idx_inc];
                    end
                end
            end

            default: begin  // c_GAP
                w_clk_nx  = 1'b1;
                w_data_nx = 1'b1;
                if (r_cnt == c_GAP_LAST) begin
                    w_state_nx = c_IDLE;
                    w_cnt_nx   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 4'd0;
            r_shift   <= 9'd0;
            r_clk     <= 1'b1;
            r_data    <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_bit_idx <= w_idx_nx;
            r_clk     <= w_clk_nx;
            r_data    <= w_data_nx;
            if (w_latch) begin
                r_shift <= {~^w_head, w_head};
            end
        end
    end

    assign ps2_clk  = r_clk;
    assign ps2_data = r_data;
    assign busy     = (r_state != c_IDLE);

endmodule
`default_nettype wire
